// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the peripheral endpoint and the controller side.
package spi_pkg;
    localparam logic SPI_CPOL = 1'b1;
    localparam logic SPI_CPHA = 1'b1;

    localparam int                   SPI_MAX_W     = 32;
    localparam logic [SPI_MAX_W-1:0] SPI_FILL_WORD = '0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses taken against one extra registered copy.
// Latency: q_o is STAGES cycles behind d_i, edge pulses are valid in that same cycle; no backpressure.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_peripheral_byte_if.sv
// Mode-3 SPI peripheral with byte rx pulse / 1-entry tx holding register; rx_valid_o SYNC_STAGES+2 clocks after last SCLK rise,
// rx has no backpressure, tx_ready_o drops while holding is full. Define SPI_PERIPHERAL_UNDERRUN_DET_EN to add tx_underrun_o.
module spi_peripheral_byte_if
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              spi_sclk_i,
    input  logic              spi_csn_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o
`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
    ,
    output logic              tx_underrun_o
`endif
);
    localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] FILL  = SPI_FILL_WORD[DATA_W-1:0];

    logic sclk_s, sclk_rise, sclk_fall;
    logic csn_s, csn_rise, csn_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sclk (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (spi_sclk_i),
        .q_o    (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (spi_csn_i),
        .q_o    (csn_s),
        .rise_o (csn_rise),
        .fall_o (csn_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (spi_mosi_i),
        .q_o    (mosi_s),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    // CPOL==CPHA: data launched on the leading (falling) edge, sampled on the trailing one
    logic launch_edge, sample_edge;
    assign launch_edge = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;
    assign sample_edge = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;

    spi_state_e        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] tx_sr_q, rx_sr_q, hold_q, hold_d, rx_data_q;
    logic              hold_full_q, hold_full_d;
    logic              miso_q, done_q, rx_valid_q;
    logic              word_start, tx_accept;
    logic [DATA_W-1:0] start_word;

    assign word_start = (state_q == ST_ACTIVE) && !csn_rise && launch_edge && (bit_cnt_q == '0);
    assign tx_accept  = tx_valid_i && !hold_full_q;
    assign start_word = hold_full_q ? hold_q : FILL;

    // A word starting with holding empty sends the fill word; a same-cycle accept is kept for the next word
    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (word_start && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (tx_accept) begin
            hold_full_d = 1'b1;
            hold_d      = tx_data_i;
        end
    end

`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
    logic underrun_q;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
            underrun_q  <= 1'b0;
`endif
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            done_q      <= 1'b0;
            rx_valid_q  <= done_q;
            if (done_q) begin
                rx_data_q <= rx_sr_q;
            end
`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
            underrun_q  <= word_start && !hold_full_q;
`endif
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q <= '0;
                    miso_q    <= 1'b0;
                    if (csn_fall) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (csn_rise) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        miso_q    <= 1'b0;
                    end else begin
                        if (launch_edge) begin
                            if (bit_cnt_q == '0) begin
                                tx_sr_q <= start_word;
                                miso_q  <= start_word[DATA_W-1];
                            end else begin
                                tx_sr_q <= tx_sr_q << 1;
                                miso_q  <= tx_sr_q[DATA_W-2];
                            end
                        end
                        if (sample_edge) begin
                            rx_sr_q <= {rx_sr_q[DATA_W-2:0], mosi_s};
                            if (bit_cnt_q == LAST) begin
                                bit_cnt_q <= '0;
                                done_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = (state_q == ST_ACTIVE);
    assign busy_o        = (state_q == ST_ACTIVE);
    assign tx_ready_o    = ~hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
    assign tx_underrun_o = underrun_q;
`endif

    // Kept for visibility in waveforms; the FSM works on the edge pulses only
    logic sync_levels_unused;
    assign sync_levels_unused = sclk_s ^ csn_s;
endmodule

// File: tb/tb_spi_peripheral_byte_if.sv
// Scoreboard bench: drives a mode-3 controller at SCLK = clk/8 and checks MISO words, rx words and rx latency.
module tb_spi_peripheral_byte_if;
    localparam int LAT = 4;  // SYNC_STAGES + 2

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sclk = 1'b1;
    logic       csn = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso, oe, tx_ready, rx_valid, busy;
    logic [7:0] rx_data;
`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
    logic       tx_underrun;
    int         und_cnt = 0;
`endif

    always #5 clk = ~clk;

    spi_peripheral_byte_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .spi_sclk_i    (sclk),
        .spi_csn_i     (csn),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (oe),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .busy_o        (busy)
`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
        ,
        .tx_underrun_o (tx_underrun)
`endif
    );

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } rx_exp_t;

    rx_exp_t    exp_rx_q[$];
    logic [7:0] exp_miso_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rx monitor: every rx_valid_o cycle must match the next expected word and its latency
    always @(posedge clk) begin
        #1;
        if (rstn && rx_valid) begin
            if (exp_rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got rx_data %0h with nothing expected", rx_data);
            end else begin
                rx_exp_t e;
                e = exp_rx_q.pop_front();
                chk("rx_data", rx_data, e.d);
                chk("rx_latency", cyc - e.cyc, LAT);
            end
        end
    end

    // MISO monitor: the controller samples MISO on rising SCLK while selected
    int         mbits = 0;
    logic [7:0] msr = 8'h00;
    always @(posedge sclk or posedge csn) begin
        if (csn !== 1'b0) begin
            mbits = 0;
        end else begin
            msr = {msr[6:0], miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected: got word %0h with nothing expected", msr);
                end else begin
                    chk("miso_word", msr, exp_miso_q.pop_front());
                end
            end
        end
    end

`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
    always @(posedge clk) begin
        #1;
        if (rstn && tx_underrun) und_cnt++;
    end
`endif

    task automatic send_bits(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = w[7-i];
            tick(4);
            sclk = 1'b1;
            if (i == 7) exp_rx_q.push_back('{d: w, cyc: cyc});
            tick(4);
        end
    endtask

    task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi);
        exp_miso_q.push_back(exp_mi);
        send_bits(mo, 8);
    endtask

    task automatic cs_low();
        csn = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        csn = 1'b1;
        tick(8);
    endtask

    task automatic tx_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        chk("rst_miso", miso, 1'b0);
        chk("rst_oe", oe, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        rstn = 1'b1;
        tick(3);

        // Basic word: holding 0xA5 returned while 0x3C is received
        tx_write(8'hA5);
        chk("t1_ready_full", tx_ready, 1'b0);
        cs_low();
        chk("t1_busy", busy, 1'b1);
        chk("t1_oe", oe, 1'b1);
        fork
            xfer(8'h3C, 8'hA5);
            begin
                tick(10);
                chk("t1_ready_after_fall", tx_ready, 1'b1);
            end
        join
        cs_high();
        chk("t1_idle_busy", busy, 1'b0);

        // Back-to-back words, second tx written during the first word
        tx_write(8'hA5);
        cs_low();
        fork
            xfer(8'h11, 8'hA5);
            begin
                tick(20);
                tx_write(8'h81);
            end
        join
        xfer(8'h22, 8'h81);
        cs_high();

        // Underrun: fill word sent
        cs_low();
        xfer(8'hFF, 8'h00);
        cs_high();

        // Aborted word after 5 bits, then an aligned full word
        cs_low();
        send_bits(8'hC3, 5);
        csn = 1'b1;
        tick(8);
        chk("t4_abort_idle", busy, 1'b0);
        cs_low();
        xfer(8'h5A, 8'h00);
        cs_high();

        // Writes while full are ignored
        tx_write(8'h11);
        chk("t5_ready_full", tx_ready, 1'b0);
        tx_data  = 8'h22;
        tx_valid = 1'b1;
        tick(3);
        chk("t5_ready_held", tx_ready, 1'b0);
        tx_valid = 1'b0;
        cs_low();
        xfer(8'h00, 8'h11);
        cs_high();
        chk("t5_ready_after", tx_ready, 1'b1);

        // Reset in the middle of a word
        tx_write(8'hFF);
        cs_low();
        send_bits(8'h96, 3);
        tx_write(8'h77);
        chk("t6_miso_pre", miso, 1'b1);
        chk("t6_ready_pre", tx_ready, 1'b0);
        rstn = 1'b0;
        #1;
        chk("t6_oe", oe, 1'b0);
        chk("t6_miso", miso, 1'b0);
        chk("t6_rx_valid", rx_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_ready", tx_ready, 1'b1);
        csn  = 1'b1;
        sclk = 1'b1;
        tick(2);
        rstn = 1'b1;
        tick(4);
        cs_low();
        xfer(8'h69, 8'h00);
        cs_high();

        tick(10);
        chk("rx_queue_drained", exp_rx_q.size(), 0);
        chk("miso_queue_drained", exp_miso_q.size(), 0);
`ifdef SPI_PERIPHERAL_UNDERRUN_DET_EN
        chk("underrun_count", und_cnt, 4);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
